prio_encoder_rr: RTL and testbench

- Parametrised, registered successor to the 8-to-3 encoder.
- Encodes an N-bit request vector to a log2(N) index with one cycle of latency and a valid/ready handshake on both sides.
- Selectable fixed-priority or round-robin tie-breaking; flags for no-request and multiple-request cases.
- Sits between request sources (interrupt lines, channel requests) and a downstream consumer that may stall.

---
 rtl/prio_encoder_rr_pkg.sv | 20 ++
 rtl/prio_encoder_rr_scan.sv | 48 ++++
 rtl/prio_encoder_rr.sv | 97 +++++++++
 tb/tb_prio_encoder_rr.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prio_encoder_rr_pkg.sv
// Shared constants and helpers for the registered priority encoder family.
// Mode selectors and a constant clog2 usable in parameter defaults.
package prio_encoder_rr_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Smallest r with 2**r >= n; usable in parameter defaults.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_encoder_rr_scan.sv
// Combinational circular find-first: first set bit of req at or after start,
// wrapping at N. Works for any N >= 2, including non-powers of two.
module prio_scan
    import prio_encoder_rr_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [N-1:0] rot;
    logic [W-1:0] first;
    logic [W:0]   sum;

    // rot[gi] = req[(start + gi) mod N]; start is always < N.
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        logic [W:0]   pos;
        logic [W-1:0] src;
        assign pos     = {1'b0, start} + (W+1)'(gi);
        assign src     = (pos >= (W+1)'(N)) ? W'(pos - (W+1)'(N)) : W'(pos);
        assign rot[gi] = req[src];
    end

    always_comb begin
        found = 1'b0;
        first = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                first = W'(i);
            end
        end
    end

    assign sum = {1'b0, first} + {1'b0, start};

    always_comb begin
        idx = '0;
        if (found) begin
            idx = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);
        end
    end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-input priority encoder with valid/ready on both sides and
// fixed-priority or round-robin arbitration between simultaneous requests.
module prio_encoder_rr
    import prio_encoder_rr_pkg::*;
#(
    parameter int N    = 8,
    parameter int W    = clog2(N),
    parameter int MODE = MODE_FIXED
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [N-1:0] in_req,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         out_none,
    output logic         out_multi
);

    logic         valid_q, valid_d;
    logic [W-1:0] idx_q, idx_d;
    logic [N-1:0] onehot_q, onehot_d;
    logic         none_q, none_d;
    logic         multi_q, multi_d;
    logic [W-1:0] rr_ptr_q, rr_ptr_d;

    logic [W-1:0] scan_start;
    logic [W-1:0] scan_idx;
    logic         scan_found;
    logic         accept;

    // Fixed priority is the round-robin search pinned to a start of 0.
    assign scan_start = (MODE == MODE_RR) ? rr_ptr_q : '0;

    prio_scan #(
        .N (N),
        .W (W)
    ) u_scan (
        .req   (in_req),
        .start (scan_start),
        .idx   (scan_idx),
        .found (scan_found)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d  = valid_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        none_d   = none_q;
        multi_d  = multi_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            valid_d  = 1'b1;
            idx_d    = scan_found ? scan_idx : '0;
            onehot_d = scan_found ? (N'(1) << scan_idx) : '0;
            none_d   = !scan_found;
            // Clearing the lowest set bit leaves something iff two or more were set.
            multi_d  = |(in_req & (in_req - N'(1)));
            if (scan_found && (MODE == MODE_RR)) begin
                rr_ptr_d = (scan_idx == W'(N - 1)) ? '0 : scan_idx + W'(1);
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
            none_q   <= 1'b0;
            multi_q  <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            none_q   <= none_d;
            multi_q  <= multi_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_idx    = idx_q;
    assign out_onehot = onehot_q;
    assign out_none   = none_q;
    assign out_multi  = multi_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: three instances (N=8 fixed, N=8 round-robin,
// N=5 round-robin) driven in lockstep and checked against a behavioural model.
module tb_prio_encoder_rr;
    import prio_encoder_rr_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] in_req = 8'h00;

    logic       rdy0, ov0, none0, multi0;
    logic [2:0] idx0;
    logic [7:0] oh0;
    logic       rdy1, ov1, none1, multi1;
    logic [2:0] idx1;
    logic [7:0] oh1;
    logic       rdy5, ov5, none5, multi5;
    logic [2:0] idx5;
    logic [4:0] oh5;

    int n_vec = 0;
    int n_err = 0;

    int         m_n[3]    = '{8, 8, 5};
    int         m_mode[3] = '{0, 1, 1};
    bit         m_valid[3];
    int         m_idx[3];
    logic [7:0] m_oh[3];
    bit         m_none[3];
    bit         m_multi[3];
    int         m_ptr[3];

    always #5 clk = ~clk;

    prio_encoder_rr #(.N(8), .MODE(MODE_FIXED)) u_d0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_req(in_req),
        .in_ready(rdy0), .out_valid(ov0), .out_ready(out_ready), .out_idx(idx0),
        .out_onehot(oh0), .out_none(none0), .out_multi(multi0)
    );

    prio_encoder_rr #(.N(8), .MODE(MODE_RR)) u_d1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_req(in_req),
        .in_ready(rdy1), .out_valid(ov1), .out_ready(out_ready), .out_idx(idx1),
        .out_onehot(oh1), .out_none(none1), .out_multi(multi1)
    );

    prio_encoder_rr #(.N(5), .MODE(MODE_RR)) u_d5 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_req(in_req[4:0]),
        .in_ready(rdy5), .out_valid(ov5), .out_ready(out_ready), .out_idx(idx5),
        .out_onehot(oh5), .out_none(none5), .out_multi(multi5)
    );

    // First set position walking ptr, ptr+1, ... modulo n; -1 if none.
    function automatic int winner(input logic [7:0] req, input int ptr, input int n);
        for (int k = 0; k < n; k++) begin
            if (req[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    function automatic logic [14:0] exp_vec(input int d);
        return {(!m_valid[d] || out_ready), m_valid[d], 3'(m_idx[d]), m_oh[d],
                m_none[d], m_multi[d]};
    endfunction

    function automatic logic [14:0] got_vec(input int d);
        if (d == 0) return {rdy0, ov0, idx0, oh0, none0, multi0};
        if (d == 1) return {rdy1, ov1, idx1, oh1, none1, multi1};
        return {rdy5, ov5, idx5, 3'b000, oh5, none5, multi5};
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 3; d++) begin
            logic [7:0] req;
            int         w;
            req = in_req & 8'((1 << m_n[d]) - 1);
            if (reset) begin
                m_valid[d] = 0; m_idx[d] = 0; m_oh[d] = 8'h00;
                m_none[d] = 0; m_multi[d] = 0; m_ptr[d] = 0;
            end else if (in_valid && (!m_valid[d] || out_ready)) begin
                w = winner(req, m_ptr[d], m_n[d]);
                m_valid[d] = 1;
                m_none[d]  = (w < 0);
                m_idx[d]   = (w < 0) ? 0 : w;
                m_oh[d]    = (w < 0) ? 8'h00 : 8'(1 << w);
                m_multi[d] = ($countones(req) >= 2);
                if (w >= 0 && m_mode[d] == 1) m_ptr[d] = (w == m_n[d] - 1) ? 0 : w + 1;
            end else if (m_valid[d] && out_ready) begin
                m_valid[d] = 0;
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_req = 8'hFF; out_ready = 1'b1;
        cycle();
        cycle();
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (got_vec(d) !== 15'h4000) begin
                n_err++;
                $display("FAIL reset dut%0d got=%h exp=%h", d, got_vec(d), 15'h4000);
            end
        end
        reset = 1'b0; in_valid = 1'b0; in_req = 8'h00;
    endtask

    task automatic test_onehot_walk();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_req = 8'(1 << i);
            cycle();
            n_vec++;
            if (ov0 !== 1'b1 || idx0 !== 3'(i) || multi0 !== 1'b0) begin
                n_err++;
                $display("FAIL walk req=%h got v/idx/multi=%b/%0d/%b exp 1/%0d/0",
                         in_req, ov0, idx0, multi0, i);
            end
            for (int d = 0; d < 3; d++) begin
                n_vec++;
                if (got_vec(d) !== exp_vec(d)) begin
                    n_err++;
                    $display("FAIL walk_model dut%0d got=%h exp=%h", d, got_vec(d), exp_vec(d));
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_fixed_cases();
        in_valid = 1'b1; out_ready = 1'b1; in_req = 8'hA4;
        cycle();
        n_vec++;
        if ({idx0, oh0, none0, multi0} !== {3'd2, 8'h04, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL fixed_A4 got idx=%0d oh=%h none=%b multi=%b exp idx=2 oh=04 none=0 multi=1",
                     idx0, oh0, none0, multi0);
        end
        in_req = 8'h00;
        cycle();
        n_vec++;
        if ({ov0, idx0, oh0, none0, multi0} !== {1'b1, 3'd0, 8'h00, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL fixed_zero got v=%b idx=%0d oh=%h none=%b multi=%b exp v=1 idx=0 oh=00 none=1 multi=0",
                     ov0, idx0, oh0, none0, multi0);
        end
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (got_vec(d) !== exp_vec(d)) begin
                n_err++;
                $display("FAIL fixed_model dut%0d got=%h exp=%h", d, got_vec(d), exp_vec(d));
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_rr_wrap();
        int exp_seq[4] = '{0, 4, 7, 0};
        reset = 1'b1;
        cycle();
        reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_req = 8'h91;
        for (int k = 0; k < 4; k++) begin
            cycle();
            n_vec++;
            if (ov1 !== 1'b1 || idx1 !== 3'(exp_seq[k])) begin
                n_err++;
                $display("FAIL rr_wrap step%0d got v=%b idx=%0d exp v=1 idx=%0d", k, ov1, idx1, exp_seq[k]);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; out_ready = 1'b1; in_req = 8'h10;
        cycle();
        out_ready = 1'b0; in_req = 8'h01;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_vec++;
            if (rdy0 !== 1'b0 || ov0 !== 1'b1 || idx0 !== 3'd4) begin
                n_err++;
                $display("FAIL backpressure cyc%0d got rdy=%b v=%b idx=%0d exp rdy=0 v=1 idx=4",
                         k, rdy0, ov0, idx0);
            end
        end
        out_ready = 1'b1;
        cycle();
        n_vec++;
        if (ov0 !== 1'b1 || idx0 !== 3'd0) begin
            n_err++;
            $display("FAIL back_to_back got v=%b idx=%0d exp v=1 idx=0", ov0, idx0);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; out_ready = 1'b1; in_req = 8'h0E;
        cycle();
        in_valid = 1'b0; out_ready = 1'b0;
        cycle();
        reset = 1'b1; in_valid = 1'b1; in_req = 8'h80;
        cycle();
        reset = 1'b0; in_valid = 1'b0;
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (got_vec(d) !== 15'h4000) begin
                n_err++;
                $display("FAIL reset_mid dut%0d got=%h exp=%h", d, got_vec(d), 15'h4000);
            end
        end
        in_valid = 1'b1; out_ready = 1'b1; in_req = 8'hFF;
        cycle();
        n_vec++;
        if (ov1 !== 1'b1 || idx1 !== 3'd0) begin
            n_err++;
            $display("FAIL reset_mid_rr got v=%b idx=%0d exp v=1 idx=0", ov1, idx1);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_n5_wrap();
        reset = 1'b1;
        cycle();
        reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_req = 8'h10;
        cycle();
        n_vec++;
        if (idx5 !== 3'd4 || oh5 !== 5'h10) begin
            n_err++;
            $display("FAIL n5_first got idx=%0d oh=%h exp idx=4 oh=10", idx5, oh5);
        end
        in_req = 8'h11;
        cycle();
        n_vec++;
        if (idx5 !== 3'd0 || multi5 !== 1'b1) begin
            n_err++;
            $display("FAIL n5_wrap got idx=%0d multi=%b exp idx=0 multi=1", idx5, multi5);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            reset     = ($urandom_range(0, 40) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       in_req = 8'h00;
                1:       in_req = 8'($urandom);
                default: in_req = 8'($urandom) & 8'($urandom);
            endcase
            cycle();
            for (int d = 0; d < 3; d++) begin
                n_vec++;
                if (got_vec(d) !== exp_vec(d)) begin
                    n_err++;
                    $display("FAIL random k%0d dut%0d got=%h exp=%h", k, d, got_vec(d), exp_vec(d));
                end
            end
        end
        reset = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_onehot_walk();
        test_fixed_cases();
        test_rr_wrap();
        test_backpressure();
        test_reset_mid();
        test_n5_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
